timer_share_scheduler: RTL and testbench
========================================

Name: timer_share_scheduler

Overview:
- Time-multiplexes the single system interval timer between NUM_REQ hardware requesters, each needing a one-shot timeout of a requested length.
- Round-robin arbitration picks the next requester. The block then programs the timer over its 16-bit register-slave port (period low/high, control), waits for the timer irq, clears the timer status and pulses done to the owner.
- Sits between hardware clients (DMA watchdogs, protocol timeouts) and the timer slave, in place of software access.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of owner index; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- req  in  NUM_REQ  per-requester request level; held until ack.
- req_period  in  NUM_REQ*32  packed timeout lengths; slice i = bits [32i+31:32i].
- cancel  in  NUM_REQ  per-requester abort pulse.
- ack  out  NUM_REQ  one-cycle pulse; request accepted, period sampled.
- done  out  NUM_REQ  one-cycle pulse; timeout expired for owner.
- cancelled  out  NUM_REQ  one-cycle pulse; owner's abort completed.
- busy  out  1  high when state != IDLE.
- owner  out  IDX_W  index of current owner; valid while busy.
- tmr_address  out  3  timer register address.
- tmr_chipselect  out  1  timer select.
- tmr_write_n  out  1  timer write strobe, active-low.
- tmr_writedata  out  16  timer write data.
- tmr_irq  in  1  timer interrupt (level, cleared by status write).

Behaviour:
- Reset values:
  - ack, done, cancelled = 0; busy = 0; owner = 0.
  - tmr_chipselect = 0, tmr_write_n = 1, tmr_address = 0, tmr_writedata = 0.
  - RR pointer = 0; state = IDLE.
- All outputs are registered.
- Timer map: 0 status (write clears TO), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h.
- Zero-wait-state writes: each write state drives chipselect=1, write_n=0 for exactly one cycle. All other states drive chipselect=0, write_n=1.
- FSM:
  - IDLE: if any req, grant the first set bit at or after the RR pointer, wrapping. Latch owner and period, pulse ack[owner], go to WR_PL.
  - A req period of 0 is clamped to 1.
  - WR_PL: addr 2, data period[15:0] -> WR_PH.
  - WR_PH: addr 3, data period[31:16] -> WR_CTRL.
  - WR_CTRL: addr 1, data 0x0005 (ITO|START, CONT=0) -> WAIT_IRQ.
  - WAIT_IRQ: on tmr_irq=1 -> CLR_ST with done_pending set. On cancel[owner] -> WR_STOP.
  - WR_STOP: addr 1, data 0x0008 (STOP, ITO=0) -> CLR_ST with cancel_pending set.
  - CLR_ST: addr 0, data 0x0000 -> FIN.
  - FIN: pulse done[owner] or cancelled[owner]. Set RR pointer = owner+1 mod NUM_REQ. Go to IDLE.
- Cancel rules:
  - cancel[owner] seen in WR_PL/WR_PH/WR_CTRL sets cancel_pending. After the current write completes, go to WR_STOP.
  - cancel on a non-owner index is ignored (no pulse).
  - cancel in CLR_ST/FIN is ignored; done still fires.
- Simultaneous tmr_irq and cancel[owner] in WAIT_IRQ: irq wins, done pulses, no cancelled.
- tmr_irq is ignored outside WAIT_IRQ.
- Any new req during busy waits; it is not lost, since req is held.
- Fixed overhead: ack cycle + 3 writes before the timer starts; 2 cycles (CLR_ST, FIN) after irq.
- Back-to-back: after FIN, IDLE may grant on the next cycle.
- Reset mid-operation: FSM returns to IDLE with no done/cancelled pulse. Bus outputs go to reset values immediately (asynchronous).

Decomposition:
- Package timer_share_pkg holds:
  - state enum (IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, WR_STOP, CLR_ST, FIN);
  - timer address constants (ADDR_STATUS=0, ADDR_CONTROL=1, ADDR_PERIODL=2, ADDR_PERIODH=3);
  - control constants (CTRL_START_IRQ=16'h0005, CTRL_STOP=16'h0008).
- One sub-module, rr_arbiter: NUM_REQ-wide combinational priority pick from the pointer, returning a one-hot grant and an index.

Test Plan:
- req=0010, period[1]=0x0001_86A0 -> ack[1] next cycle; writes in order (2,0x86A0),(3,0x0001),(1,0x0005); irq asserted -> write (0,0x0000), then done[1] two cycles after irq.
- req=1111 held, each period 10 -> serviced in order 0,1,2,3. After owner 3, pointer wraps to 0.
- Owner 2 in WAIT_IRQ, cancel[2] -> write (1,0x0008), then (0,0x0000), then cancelled[2]; no done[2].
- irq and cancel[owner] in same WAIT_IRQ cycle -> done[owner] only. cancel[non-owner] at any time -> no effect.
- req[0] with period 0 -> writes period_l=0x0001, period_h=0x0000.
- reset_n low during WR_PH -> chipselect=0, write_n=1, busy=0 at once. After release, pending req re-granted starting from pointer 0.

Source files
------------

// File: rtl/timer_share_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_share_pkg
//  Description : Shared types and constants for the timer share scheduler:
//                FSM state encoding, timer register map and control words.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_share_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_PL    = 3'd1,
      WR_PH    = 3'd2,
      WR_CTRL  = 3'd3,
      WAIT_IRQ = 3'd4,
      WR_STOP  = 3'd5,
      CLR_ST   = 3'd6,
      FIN      = 3'd7
   } state_t;

   // Timer register map
   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIODL = 3'd2;
   localparam logic [2:0] ADDR_PERIODH = 3'd3;

   // Control words: one-shot start with irq enabled, and stop with irq masked
   localparam logic [15:0] CTRL_START_IRQ = 16'h0005;
   localparam logic [15:0] CTRL_STOP      = 16'h0008;

endpackage
`default_nettype wire

// File: rtl/timer_share_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_share_scheduler_if
//  Description : Register-slave bus between the scheduler and the interval
//                timer, plus the timer interrupt line.
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_share_scheduler_if;

   logic [2:0]  tmr_address;
   logic        tmr_chipselect;
   logic        tmr_write_n;
   logic [15:0] tmr_writedata;
   logic        tmr_irq;

   modport master (
      output tmr_address,
      output tmr_chipselect,
      output tmr_write_n,
      output tmr_writedata,
      input  tmr_irq
   );

   modport slave (
      input  tmr_address,
      input  tmr_chipselect,
      input  tmr_write_n,
      input  tmr_writedata,
      output tmr_irq
   );

endinterface
`default_nettype wire

// File: rtl/timer_share_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick: first set request at or
//                after the pointer, wrapping. Returns one-hot grant and index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   int   w_j;
   logic w_found;

   // Scan NUM_REQ positions starting at the pointer; first hit wins
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      w_found = 1'b0;
      w_j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_j = int'(ptr_i) + k;
         if (w_j >= NUM_REQ) begin
            w_j = w_j - NUM_REQ;
         end
         if (!w_found && req_i[w_j]) begin
            w_found       = 1'b1;
            grant_o[w_j]  = 1'b1;
            idx_o         = IDX_W'(w_j);
         end
      end
      valid_o = w_found;
   end

endmodule
`default_nettype wire

// File: rtl/timer_share_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_share_scheduler
//  Description : Shares one interval timer between NUM_REQ requesters. Picks
//                an owner round-robin, programs a one-shot timeout over the
//                timer register port, waits for the irq (or a cancel), clears
//                the timer status and reports done/cancelled to the owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_share_scheduler
   import timer_share_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*32-1:0]  req_period,
   input  logic [NUM_REQ-1:0]     cancel,
   output logic [NUM_REQ-1:0]     ack,
   output logic [NUM_REQ-1:0]     done,
   output logic [NUM_REQ-1:0]     cancelled,
   output logic                   busy,
   output logic [IDX_W-1:0]       owner,
   timer_share_scheduler_if.master tmr
);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [31:0]          period_q, period_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic                 abort_q, abort_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [NUM_REQ-1:0]   cancelled_q, cancelled_d;
   logic                 busy_q, busy_d;
   logic [2:0]           addr_q, addr_d;
   logic                 cs_q, cs_d;
   logic                 wrn_q, wrn_d;
   logic [15:0]          wdata_q, wdata_d;

   logic [NUM_REQ-1:0]   w_grant;
   logic [IDX_W-1:0]     w_grant_idx;
   logic                 w_grant_valid;
   logic                 w_cancel_own;
   logic [NUM_REQ-1:0]   w_owner_oh;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .grant_o (w_grant),
      .idx_o   (w_grant_idx),
      .valid_o (w_grant_valid)
   );

   assign w_cancel_own = cancel[owner_q];
   assign w_owner_oh   = NUM_REQ'(1) << owner_q;

   // Next-state, latched owner/period and pulse generation
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      period_d    = period_q;
      ptr_d       = ptr_q;
      abort_d     = abort_q;
      ack_d       = '0;
      done_d      = '0;
      cancelled_d = '0;
      unique case (state_q)
         IDLE: begin
            if (w_grant_valid) begin
               owner_d  = w_grant_idx;
               period_d = req_period[32*int'(w_grant_idx) +: 32];
               if (period_d == 32'd0) begin
                  period_d = 32'd1;
               end
               abort_d  = 1'b0;
               ack_d    = w_grant;
               state_d  = WR_PL;
            end
         end
         WR_PL: begin
            abort_d = abort_q | w_cancel_own;
            state_d = abort_d ? WR_STOP : WR_PH;
         end
         WR_PH: begin
            abort_d = abort_q | w_cancel_own;
            state_d = abort_d ? WR_STOP : WR_CTRL;
         end
         WR_CTRL: begin
            abort_d = abort_q | w_cancel_own;
            state_d = abort_d ? WR_STOP : WAIT_IRQ;
         end
         WAIT_IRQ: begin
            // The irq takes priority over a same-cycle cancel
            if (tmr.tmr_irq) begin
               abort_d = 1'b0;
               state_d = CLR_ST;
            end else if (w_cancel_own) begin
               abort_d = 1'b1;
               state_d = WR_STOP;
            end
         end
         WR_STOP: begin
            abort_d = 1'b1;
            state_d = CLR_ST;
         end
         CLR_ST: begin
            // Pulses are registered so they are visible during FIN
            if (abort_q) begin
               cancelled_d = w_owner_oh;
            end else begin
               done_d = w_owner_oh;
            end
            state_d = FIN;
         end
         FIN: begin
            ptr_d   = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs decoded from the upcoming state so each write lasts exactly the state's cycle
   always_comb begin
      cs_d    = 1'b0;
      wrn_d   = 1'b1;
      addr_d  = '0;
      wdata_d = '0;
      busy_d  = (state_d != IDLE);
      unique case (state_d)
         WR_PL: begin
            cs_d = 1'b1; wrn_d = 1'b0; addr_d = ADDR_PERIODL; wdata_d = period_d[15:0];
         end
         WR_PH: begin
            cs_d = 1'b1; wrn_d = 1'b0; addr_d = ADDR_PERIODH; wdata_d = period_d[31:16];
         end
         WR_CTRL: begin
            cs_d = 1'b1; wrn_d = 1'b0; addr_d = ADDR_CONTROL; wdata_d = CTRL_START_IRQ;
         end
         WR_STOP: begin
            cs_d = 1'b1; wrn_d = 1'b0; addr_d = ADDR_CONTROL; wdata_d = CTRL_STOP;
         end
         CLR_ST: begin
            cs_d = 1'b1; wrn_d = 1'b0; addr_d = ADDR_STATUS; wdata_d = 16'h0000;
         end
         default: begin
            cs_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs, asynchronously cleared
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         period_q    <= '0;
         ptr_q       <= '0;
         abort_q     <= 1'b0;
         ack_q       <= '0;
         done_q      <= '0;
         cancelled_q <= '0;
         busy_q      <= 1'b0;
         addr_q      <= '0;
         cs_q        <= 1'b0;
         wrn_q       <= 1'b1;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         period_q    <= period_d;
         ptr_q       <= ptr_d;
         abort_q     <= abort_d;
         ack_q       <= ack_d;
         done_q      <= done_d;
         cancelled_q <= cancelled_d;
         busy_q      <= busy_d;
         addr_q      <= addr_d;
         cs_q        <= cs_d;
         wrn_q       <= wrn_d;
         wdata_q     <= wdata_d;
      end
   end

   assign ack                = ack_q;
   assign done               = done_q;
   assign cancelled          = cancelled_q;
   assign busy               = busy_q;
   assign owner              = owner_q;
   assign tmr.tmr_address    = addr_q;
   assign tmr.tmr_chipselect = cs_q;
   assign tmr.tmr_write_n    = wrn_q;
   assign tmr.tmr_writedata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_share_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_share_scheduler
//  Description : Directed self-checking bench for timer_share_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_share_scheduler;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   logic                  clk;
   logic                  reset_n;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*32-1:0] req_period;
   logic [NUM_REQ-1:0]    cancel;
   logic [NUM_REQ-1:0]    ack;
   logic [NUM_REQ-1:0]    done;
   logic [NUM_REQ-1:0]    cancelled;
   logic                  busy;
   logic [IDX_W-1:0]      owner;

   int n_checks;
   int n_errors;

   timer_share_scheduler_if tif ();

   timer_share_scheduler #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .req_period (req_period),
      .cancel     (cancel),
      .ack        (ack),
      .done       (done),
      .cancelled  (cancelled),
      .busy       (busy),
      .owner      (owner),
      .tmr        (tif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Current cycle must be a single write of (a, d)
   task automatic check_wr(input string tag, input logic [2:0] a, input logic [15:0] d);
      check({tag, "_strobe"}, 32'(tif.tmr_chipselect & ~tif.tmr_write_n), 32'd1);
      check({tag, "_addr"},   32'(tif.tmr_address), 32'(a));
      check({tag, "_data"},   32'(tif.tmr_writedata), 32'(d));
   endtask

   task automatic wait_ack(input int idx);
      int n;
      n = 0;
      while (ack == '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ack", 32'(ack), 32'(1 << idx));
      check("ack_owner", 32'(owner), 32'(idx));
   endtask

   // mode 0: irq, 1: cancel in WAIT_IRQ, 2: irq and cancel same cycle
   task automatic run_job(input int idx, input logic [31:0] per, input int mode);
      logic [31:0] p;
      p = (per == 32'd0) ? 32'd1 : per;
      wait_ack(idx);
      req[idx] = 1'b0;
      check_wr("wr_pl", 3'd2, p[15:0]);
      @(negedge clk);
      check_wr("wr_ph", 3'd3, p[31:16]);
      @(negedge clk);
      check_wr("wr_ctrl", 3'd1, 16'h0005);
      @(negedge clk);
      check("wait_cs", 32'(tif.tmr_chipselect), 32'd0);
      check("wait_busy", 32'(busy), 32'd1);
      cancel = NUM_REQ'(1 << ((idx + 1) % NUM_REQ));
      @(negedge clk);
      cancel = '0;
      check("nonowner_cancel_cs", 32'(tif.tmr_chipselect), 32'd0);
      if (mode != 1) tif.tmr_irq = 1'b1;
      if (mode != 0) cancel[idx] = 1'b1;
      @(negedge clk);
      tif.tmr_irq = 1'b0;
      cancel      = '0;
      if (mode == 1) begin
         check_wr("wr_stop", 3'd1, 16'h0008);
         @(negedge clk);
      end
      check_wr("clr_st", 3'd0, 16'h0000);
      @(negedge clk);
      check("done", 32'(done), (mode == 1) ? 32'd0 : 32'(1 << idx));
      check("cancelled", 32'(cancelled), (mode == 1) ? 32'(1 << idx) : 32'd0);
      @(negedge clk);
      check("done_clear", 32'(done | cancelled), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      reset_n     = 1'b0;
      req         = '0;
      cancel      = '0;
      req_period  = '0;
      tif.tmr_irq = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cs", 32'(tif.tmr_chipselect), 32'd0);
      check("rst_wrn", 32'(tif.tmr_write_n), 32'd1);
      check("rst_addr", 32'(tif.tmr_address), 32'd0);
      check("rst_pulses", 32'(ack | done | cancelled), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // All four requesting: serviced 0,1,2,3 then pointer wraps to 0
      for (int i = 0; i < NUM_REQ; i++) req_period[32*i +: 32] = 32'd10;
      req = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) run_job(i, 32'd10, 0);

      // Pointer at 0: req 1010 grants 1 first, then 3 with irq+cancel together
      req_period[63:32] = 32'h0001_86A0;
      req = 4'b1010;
      run_job(1, 32'h0001_86A0, 0);
      run_job(3, 32'd10, 2);

      // Cancel while waiting for the irq
      req = 4'b0100;
      run_job(2, 32'd10, 1);

      // Zero period clamps to one
      req_period[31:0] = 32'd0;
      req = 4'b0001;
      run_job(0, 32'd0, 0);

      // Cancel during the period-low write jumps straight to STOP
      req_period[63:32] = 32'h0002_0003;
      req = 4'b0010;
      wait_ack(1);
      req = '0;
      check_wr("early_pl", 3'd2, 16'h0003);
      cancel = 4'b0010;
      @(negedge clk);
      cancel = '0;
      check_wr("early_stop", 3'd1, 16'h0008);
      @(negedge clk);
      check_wr("early_clr", 3'd0, 16'h0000);
      @(negedge clk);
      check("early_done", 32'(done), 32'd0);
      check("early_cancelled", 32'(cancelled), 32'b0010);
      @(negedge clk);

      // Reset during WR_PH, then restart arbitration from pointer 0
      req_period[95:64] = 32'd7;
      req_period[31:0]  = 32'h20;
      req = 4'b0100;
      wait_ack(2);
      @(negedge clk);
      check_wr("pre_rst_ph", 3'd3, 16'h0000);
      reset_n = 1'b0;
      #1;
      check("mid_rst_cs", 32'(tif.tmr_chipselect), 32'd0);
      check("mid_rst_wrn", 32'(tif.tmr_write_n), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      req = 4'b0101;
      @(negedge clk);
      check("mid_rst_pulses", 32'(ack | done | cancelled), 32'd0);
      reset_n = 1'b1;
      run_job(0, 32'h20, 0);
      run_job(2, 32'd7, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
